// File: rtl/neighbor_link_rx.sv
// Receive FIFO for the inter-core neighbor channel; serves LDNEIGHBOR in execute.
// Optional NEIGHBOR_RX_BYPASS_EN: an empty-FIFO load takes the incoming word directly.
module neighbor_link_rx #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2,
    parameter int unsigned DATA_W = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nbr_valid,
    input  logic [DATA_W-1:0] nbr_data,
    output logic              nbr_ready,
    input  logic              ld_req,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_stall,
    input  logic              flush,
    output logic [PTR_W:0]    occupancy,
    output logic              overflow_err
);

    localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;
    logic              bypass;
    logic              push;
    logic              pop;

    assign full  = (count == FullCount);
    assign empty = (count == '0);

`ifdef NEIGHBOR_RX_BYPASS_EN
    assign bypass = empty && ld_req && nbr_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Ready comes from registered state only, so no path crosses between cores.
    assign nbr_ready = !full;
    assign push      = nbr_valid && nbr_ready && !bypass && !flush;
    assign pop       = ld_req && !empty && !flush;
    assign ld_stall  = ld_req && empty && !bypass;
    assign occupancy = count;

    always_comb begin
        ld_data = '0;
        if (bypass) begin
            ld_data = nbr_data;
        end else if (!empty) begin
            ld_data = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= nbr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky protocol monitor; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (nbr_valid && !nbr_ready) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: doc/neighbor_link_rx.md
Name: neighbor_link_rx

Overview:
- Receiving end of the inter-core neighbor channel. A STRNEIGHBOR executed on the adjacent core pushes a 40-bit word across the link; this block buffers it and serves it to LDNEIGHBOR in the local execute stage.
- Sits beside the execute stage. Its ld_stall output is ORed into the execute hazard stall, because a neighbor load cannot be forwarded and must wait for data.
- Ready is decoupled from local load activity, so there is no combinational path between cores.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- DATA_W, 40, word width; matches the register file word.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- nbr_valid  input  1  neighbor presents a word (its STRNEIGHBOR in execute).
- nbr_data  input  DATA_W  word from neighbor.
- nbr_ready  output  1  local side can accept a word this cycle.
- ld_req  input  1  LDNEIGHBOR in local pipe 0 execute.
- ld_data  output  DATA_W  word returned to execute result path.
- ld_stall  output  1  load cannot complete this cycle; hold execute.
- flush  input  1  synchronous clear of all buffered words (core restart/HALT recovery).
- occupancy  output  PTR_W+1  number of buffered words.
- overflow_err  output  1  sticky: nbr_valid was seen while nbr_ready was low.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - rd_ptr, wr_ptr and count to 0;
  - overflow_err to 0.
- Outputs while in reset:
  - nbr_ready = 1 (empty FIFO);
  - ld_stall = ld_req;
  - ld_data = 0.
- Storage registers are not reset. ld_data is forced to 0 whenever the FIFO is empty.
- Full = (count == DEPTH); empty = (count == 0).
- nbr_ready = !full. It depends only on registered state, never on ld_req in the same cycle.
- Push = nbr_valid && nbr_ready. On push, nbr_data is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap).
- Pop = ld_req && !empty. ld_data = mem[rd_ptr], combinational from registered storage. rd_ptr increments modulo DEPTH at the clock edge. Load latency is 0 cycles when data is already present.
- ld_stall = ld_req && empty (base build). While stalled, the pipeline holds ld_req high; the load completes in the first cycle after a word has been pushed.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, no push occurs even if a pop happens that cycle; the neighbor retries next cycle.
- A word pushed in cycle N is poppable no earlier than cycle N+1 (base build).
- Pushing into an empty FIFO while ld_req is high therefore costs exactly one stall cycle.
- Overflow: if nbr_valid && !nbr_ready, set overflow_err. It is sticky until reset; flush does not clear it.
- The neighbor is required to hold nbr_valid and nbr_data stable until accepted. The error flags a protocol monitor condition only; the data is not lost.
- Flush (synchronous):
  - Pointers and count go to 0 at the next edge.
  - Any push or pop in the flush cycle is discarded.
  - ld_stall in the flush cycle still follows the pre-flush empty state.
- Reset asserted mid-transfer: the buffered words and the in-flight push are dropped. The neighbor side observes nbr_ready = 1 immediately (asynchronous).
- occupancy = count, registered.

Optional Feature:
- Macro: NEIGHBOR_RX_BYPASS_EN.
- Defined: when the FIFO is empty and ld_req && nbr_valid hold in the same cycle (and flush is low):
  - ld_data = nbr_data and ld_stall = 0;
  - the word is consumed directly, with no write, no pointer change and count remaining 0;
  - nbr_ready stays 1 as usual.
- Not defined: the same situation gives ld_stall = 1, the word is pushed, and the load completes next cycle.

Test Plan:
- Reset, then push 0x00_1234_5678, 0x00_0000_00AA over two cycles, ld_req low -> occupancy 2, nbr_ready 1. Then ld_req for 2 cycles -> ld_data 0x0012345678 then 0x00000000AA, ld_stall 0, occupancy 0.
- ld_req high with FIFO empty for 3 cycles, push 0x7F_FFFF_FFFF in cycle 3 -> ld_stall 1,1,1 and 0 in cycle 4 with that word (base build). With NEIGHBOR_RX_BYPASS_EN: ld_stall low in cycle 3 and occupancy stays 0.
- Push 4 words (DEPTH=4) -> nbr_ready 0. Assert nbr_valid again -> overflow_err 1 and the word is not stored. Pop one -> nbr_ready 1 next cycle and the held word is accepted.
- Stream 10 words with simultaneous push/pop each cycle from occupancy 1 -> occupancy constant 1, data returned in order, pointers wrap twice without corruption.
- Occupancy 3, assert flush in the same cycle as push and ld_req -> next cycle occupancy 0, the pushed word is discarded, and overflow_err is unchanged.
- Occupancy 2, drop rst_n asynchronously between edges -> nbr_ready 1, occupancy 0 and overflow_err 0 immediately. After release, ld_req gives ld_stall 1.
